// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit:
// opcodes, functs, ALU codes, PC select, FSM states, instruction classes.
package ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SH    = 6'h29;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'd0;
    localparam logic [5:0] FN_SRL  = 6'd2;
    localparam logic [5:0] FN_SRA  = 6'd3;
    localparam logic [5:0] FN_JR   = 6'd8;
    localparam logic [5:0] FN_ADD  = 6'd32;
    localparam logic [5:0] FN_ADDU = 6'd33;
    localparam logic [5:0] FN_SUB  = 6'd34;
    localparam logic [5:0] FN_SUBU = 6'd35;
    localparam logic [5:0] FN_AND  = 6'd36;
    localparam logic [5:0] FN_OR   = 6'd37;
    localparam logic [5:0] FN_XOR  = 6'd38;
    localparam logic [5:0] FN_NOR  = 6'd39;
    localparam logic [5:0] FN_SLT  = 6'd42;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0011;
    localparam logic [3:0] ALU_NOR = 4'b0100;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_SRL = 4'b1000;
    localparam logic [3:0] ALU_SLL = 4'b1001;
    localparam logic [3:0] ALU_SRA = 4'b1010;

    localparam logic [2:0] PC_NEXT   = 3'b000;
    localparam logic [2:0] PC_JUMP   = 3'b001;
    localparam logic [2:0] PC_JR     = 3'b010;
    localparam logic [2:0] PC_BRANCH = 3'b011;

    typedef enum logic [2:0] {
        FETCH, DECODE, EXEC, MEM, WB
    } state_t;

    typedef enum logic [3:0] {
        R_ALU, I_ALU, BRANCH, JUMP, JAL, JR, LOAD, STORE, ILLEGAL
    } instr_class_t;

endpackage

// File: rtl/instr_decoder.sv
// Combinational classifier: opcode/funct to instruction class,
// ALU code, operand/destination muxes and store byte-lane mask.
module instr_decoder
    import ctrl_pkg::*;
#(
    parameter int DM_LANES = 4
) (
    input  logic [5:0]          op,
    input  logic [5:0]          funct,
    output instr_class_t        instr_class,
    output logic [3:0]          alu_control,
    output logic                alu_mux_select,
    output logic                reg_file_rmux_select,
    output logic [DM_LANES-1:0] lane_mask
);

    always_comb begin
        instr_class          = ILLEGAL;
        alu_control          = ALU_AND;
        alu_mux_select       = 1'b0;
        reg_file_rmux_select = 1'b0;
        lane_mask            = '0;
        unique case (op)
            OP_RTYPE: begin
                instr_class          = R_ALU;
                reg_file_rmux_select = 1'b1;
                unique case (funct)
                    FN_SLL:          alu_control = ALU_SLL;
                    FN_SRL:          alu_control = ALU_SRL;
                    FN_SRA:          alu_control = ALU_SRA;
                    FN_ADD, FN_ADDU: alu_control = ALU_ADD;
                    FN_SUB, FN_SUBU: alu_control = ALU_SUB;
                    FN_AND:          alu_control = ALU_AND;
                    FN_OR:           alu_control = ALU_OR;
                    FN_XOR:          alu_control = ALU_XOR;
                    FN_NOR:          alu_control = ALU_NOR;
                    FN_SLT:          alu_control = ALU_SLT;
                    FN_JR: begin
                        instr_class          = JR;
                        reg_file_rmux_select = 1'b0;
                        alu_control          = ALU_ADD;
                    end
                    default: begin
                        instr_class          = ILLEGAL;
                        reg_file_rmux_select = 1'b0;
                    end
                endcase
            end
            OP_ADDI, OP_ADDIU: begin
                instr_class    = I_ALU;
                alu_mux_select = 1'b1;
                alu_control    = ALU_ADD;
            end
            OP_SLTI: begin
                instr_class    = I_ALU;
                alu_mux_select = 1'b1;
                alu_control    = ALU_SLT;
            end
            OP_ANDI: begin
                instr_class    = I_ALU;
                alu_mux_select = 1'b1;
                alu_control    = ALU_AND;
            end
            OP_ORI: begin
                instr_class    = I_ALU;
                alu_mux_select = 1'b1;
                alu_control    = ALU_OR;
            end
            OP_BEQ, OP_BNE: begin
                instr_class = BRANCH;
                alu_control = ALU_SUB;
            end
            OP_J: begin
                instr_class = JUMP;
                alu_control = ALU_ADD;
            end
            OP_JAL: begin
                instr_class = JAL;
                alu_control = ALU_ADD;
            end
            OP_LW: begin
                instr_class    = LOAD;
                alu_mux_select = 1'b1;
                alu_control    = ALU_ADD;
            end
            OP_SW, OP_SH, OP_SB: begin
                instr_class    = STORE;
                alu_mux_select = 1'b1;
                alu_control    = ALU_ADD;
                // byte lanes grow sb -> sh -> sw
                lane_mask[0]   = 1'b1;
                lane_mask[1]   = (op != OP_SB);
                lane_mask[3:2] = {2{op == OP_SW}};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle MIPS control FSM (FETCH/DECODE/EXEC/MEM/WB) with MEM timeout.
// Define CTRL_TRACE_EN to print a decode trace from simulation.
module multicycle_control_unit
    import ctrl_pkg::*;
#(
    parameter int DM_LANES     = 4,
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         instruction_in,
    input  logic                instr_valid,
    output logic                instr_ready,
    input  logic                alu_zero,
    input  logic                mem_ready,
    output logic                reg_file_wren,
    output logic                reg_file_dmux_select,
    output logic                reg_file_rmux_select,
    output logic                alu_mux_select,
    output logic [3:0]          alu_control,
    output logic [DM_LANES-1:0] data_mem_wren,
    output logic                data_mem_rden,
    output logic                pc_wren,
    output logic [2:0]          pc_control,
    output logic                illegal_instr,
    output logic                mem_timeout
);

    localparam int CW = (MEM_WAIT_MAX > 0) ? $clog2(MEM_WAIT_MAX + 1) : 1;

    state_t              state, state_nxt;
    logic [31:0]         ir;
    logic [CW-1:0]       wait_cnt;
    instr_class_t        cls;
    logic [3:0]          dec_alu;
    logic                dec_amux;
    logic                dec_rmux;
    logic [DM_LANES-1:0] dec_lanes;
    logic                timed_out;
    logic                taken;
    logic                unused_ir;

    instr_decoder #(.DM_LANES(DM_LANES)) u_dec (
        .op                   (ir[31:26]),
        .funct                (ir[5:0]),
        .instr_class          (cls),
        .alu_control          (dec_alu),
        .alu_mux_select       (dec_amux),
        .reg_file_rmux_select (dec_rmux),
        .lane_mask            (dec_lanes)
    );

    assign unused_ir = ^ir[25:6];
    assign timed_out = (MEM_WAIT_MAX > 0) && (wait_cnt == CW'(MEM_WAIT_MAX));
    assign taken     = (ir[31:26] == OP_BEQ) ? alu_zero : !alu_zero;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= FETCH;
            ir       <= '0;
            wait_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == FETCH && instr_valid)
                ir <= instruction_in;
            wait_cnt <= (state == MEM && state_nxt == MEM) ?
                        wait_cnt + CW'(1) : '0;
        end
    end

    always_comb begin
        state_nxt            = state;
        instr_ready          = 1'b0;
        reg_file_wren        = 1'b0;
        reg_file_dmux_select = 1'b0;
        reg_file_rmux_select = 1'b0;
        alu_mux_select       = 1'b0;
        alu_control          = 4'b0000;
        data_mem_wren        = '0;
        data_mem_rden        = 1'b0;
        pc_wren              = 1'b0;
        pc_control           = PC_NEXT;
        illegal_instr        = 1'b0;
        mem_timeout          = 1'b0;
        // datapath selects stay stable for the whole execution phase
        if (state == EXEC || state == MEM || state == WB) begin
            alu_control          = dec_alu;
            alu_mux_select       = dec_amux;
            reg_file_rmux_select = dec_rmux;
        end
        unique case (state)
            FETCH: begin
                instr_ready = 1'b1;
                if (instr_valid)
                    state_nxt = DECODE;
            end
            DECODE: state_nxt = EXEC;
            EXEC: begin
                state_nxt = FETCH;
                unique case (cls)
                    R_ALU, I_ALU, JAL: state_nxt = WB;
                    LOAD, STORE:       state_nxt = MEM;
                    BRANCH: begin
                        pc_wren    = 1'b1;
                        pc_control = taken ? PC_BRANCH : PC_NEXT;
                    end
                    JUMP: begin
                        pc_wren    = 1'b1;
                        pc_control = PC_JUMP;
                    end
                    JR: begin
                        pc_wren    = 1'b1;
                        pc_control = PC_JR;
                    end
                    default: begin
                        illegal_instr = 1'b1;
                        pc_wren       = 1'b1;
                    end
                endcase
            end
            MEM: begin
                if (timed_out) begin
                    mem_timeout = 1'b1;
                    pc_wren     = 1'b1;
                    state_nxt   = FETCH;
                end else begin
                    data_mem_rden = (cls == LOAD);
                    data_mem_wren = (cls == STORE) ? dec_lanes : '0;
                    if (mem_ready) begin
                        if (cls == LOAD) begin
                            state_nxt = WB;
                        end else begin
                            pc_wren   = 1'b1;
                            state_nxt = FETCH;
                        end
                    end
                end
            end
            WB: begin
                reg_file_wren        = 1'b1;
                reg_file_dmux_select = (cls != LOAD);
                pc_wren              = 1'b1;
                pc_control           = (cls == JAL) ? PC_JUMP : PC_NEXT;
                state_nxt            = FETCH;
            end
            default: state_nxt = FETCH;
        endcase
    end

`ifdef CTRL_TRACE_EN
    function automatic string mnem(input logic [5:0] op,
                                   input logic [5:0] fn);
        if (op == OP_RTYPE) begin
            case (fn)
                FN_SLL:  return "sll";
                FN_SRL:  return "srl";
                FN_SRA:  return "sra";
                FN_JR:   return "jr";
                6'd16:   return "mfhi";
                6'd18:   return "mflo";
                6'd24:   return "mult";
                6'd25:   return "multu";
                6'd26:   return "div";
                6'd27:   return "divu";
                FN_ADD:  return "add";
                FN_ADDU: return "addu";
                FN_SUB:  return "sub";
                FN_SUBU: return "subu";
                FN_AND:  return "and";
                FN_OR:   return "or";
                FN_XOR:  return "xor";
                FN_NOR:  return "nor";
                FN_SLT:  return "slt";
                default: return "undef";
            endcase
        end
        case (op)
            OP_J:     return "j";
            OP_JAL:   return "jal";
            OP_BEQ:   return "beq";
            OP_BNE:   return "bne";
            OP_ADDI:  return "addi";
            OP_ADDIU: return "addiu";
            OP_SLTI:  return "slti";
            OP_ANDI:  return "andi";
            OP_ORI:   return "ori";
            6'h0F:    return "lui";
            6'h20:    return "lb";
            6'h21:    return "lh";
            6'h24:    return "lbu";
            6'h25:    return "lhu";
            OP_LW:    return "lw";
            OP_SB:    return "sb";
            OP_SH:    return "sh";
            OP_SW:    return "sw";
            default:  return "undef";
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (state == DECODE) begin
            if (ir[31:26] == OP_RTYPE)
                $display("%0t trace R %s op=%0d rs=%0d rt=%0d rd=%0d shamt=%0d funct=%0d",
                         $time, mnem(ir[31:26], ir[5:0]), ir[31:26], ir[25:21],
                         ir[20:16], ir[15:11], ir[10:6], ir[5:0]);
            else if (ir[31:26] == OP_J || ir[31:26] == OP_JAL)
                $display("%0t trace J %s op=%0d addr=%07h",
                         $time, mnem(ir[31:26], ir[5:0]), ir[31:26], ir[25:0]);
            else
                $display("%0t trace I %s op=%0d rs=%0d rt=%0d imm=%04h",
                         $time, mnem(ir[31:26], ir[5:0]), ir[31:26], ir[25:21],
                         ir[20:16], ir[15:0]);
        end
        if (illegal_instr)
            $display("%0t trace illegal_instr ir=%08h", $time, ir);
        if (mem_timeout)
            $display("%0t trace mem_timeout ir=%08h", $time, ir);
    end
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench: per-cycle output trace against a behavioural model.
module tb_multicycle_control_unit;

    localparam int WMAX = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instruction_in;
    logic        instr_valid, instr_ready, alu_zero, mem_ready;
    logic        reg_file_wren, reg_file_dmux_select, reg_file_rmux_select;
    logic        alu_mux_select, data_mem_rden, pc_wren;
    logic [3:0]  alu_control, data_mem_wren;
    logic [2:0]  pc_control;
    logic        illegal_instr, mem_timeout;

    multicycle_control_unit #(.DM_LANES(4), .MEM_WAIT_MAX(WMAX)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .instruction_in       (instruction_in),
        .instr_valid          (instr_valid),
        .instr_ready          (instr_ready),
        .alu_zero             (alu_zero),
        .mem_ready            (mem_ready),
        .reg_file_wren        (reg_file_wren),
        .reg_file_dmux_select (reg_file_dmux_select),
        .reg_file_rmux_select (reg_file_rmux_select),
        .alu_mux_select       (alu_mux_select),
        .alu_control          (alu_control),
        .data_mem_wren        (data_mem_wren),
        .data_mem_rden        (data_mem_rden),
        .pc_wren              (pc_wren),
        .pc_control           (pc_control),
        .illegal_instr        (illegal_instr),
        .mem_timeout          (mem_timeout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       rdy, rfw, dmux, rmux, amux;
        logic [3:0] alu;
        logic [3:0] dmw;
        logic       rden, pcw;
        logic [2:0] pcc;
        logic       ill, tmo;
    } obs_t;

    obs_t obs;
    assign obs = {instr_ready, reg_file_wren, reg_file_dmux_select,
                  reg_file_rmux_select, alu_mux_select, alu_control,
                  data_mem_wren, data_mem_rden, pc_wren, pc_control,
                  illegal_instr, mem_timeout};

    obs_t exp_q[$];
    obs_t idle_o;
    int   tests = 0;
    int   fails = 0;

    // kinds: 0 R-alu, 1 I-alu, 2 branch, 3 j, 4 jal, 5 jr, 6 load, 7 store, 8 illegal
    task automatic classify(input logic [31:0] ins, output int kind,
                            output logic [3:0] alu, output logic [3:0] lanes);
        logic [5:0] op;
        logic [5:0] fn;
        op = ins[31:26];
        fn = ins[5:0];
        kind = 8; alu = 4'd0; lanes = 4'd0;
        case (op)
            6'd0: begin
                kind = 0;
                case (fn)
                    6'd0:         alu = 4'b1001;
                    6'd2:         alu = 4'b1000;
                    6'd3:         alu = 4'b1010;
                    6'd32, 6'd33: alu = 4'b0010;
                    6'd34, 6'd35: alu = 4'b0110;
                    6'd36:        alu = 4'b0000;
                    6'd37:        alu = 4'b0001;
                    6'd38:        alu = 4'b0011;
                    6'd39:        alu = 4'b0100;
                    6'd42:        alu = 4'b0111;
                    6'd8:  begin kind = 5; alu = 4'b0010; end
                    default: kind = 8;
                endcase
            end
            6'd8, 6'd9: begin kind = 1; alu = 4'b0010; end
            6'd10:      begin kind = 1; alu = 4'b0111; end
            6'd12:      begin kind = 1; alu = 4'b0000; end
            6'd13:      begin kind = 1; alu = 4'b0001; end
            6'd4, 6'd5: begin kind = 2; alu = 4'b0110; end
            6'd2:       begin kind = 3; alu = 4'b0010; end
            6'd3:       begin kind = 4; alu = 4'b0010; end
            6'd35:      begin kind = 6; alu = 4'b0010; end
            6'd43: begin kind = 7; alu = 4'b0010; lanes = 4'b1111; end
            6'd41: begin kind = 7; alu = 4'b0010; lanes = 4'b0011; end
            6'd40: begin kind = 7; alu = 4'b0010; lanes = 4'b0001; end
            default: ;
        endcase
    endtask

    // expected cycle-by-cycle outputs: accept, decode, phases, then idle fetch
    task automatic build(input logic [31:0] ins, input logic z, input int d);
        int         kind;
        logic [3:0] alu, lanes;
        obs_t       e, m, w, t;
        classify(ins, kind, alu, lanes);
        exp_q.delete();
        exp_q.push_back(idle_o);
        exp_q.push_back('0);
        e = '0;
        e.alu  = alu;
        e.amux = (kind == 1 || kind == 6 || kind == 7);
        e.rmux = (kind == 0);
        case (kind)
            0, 1, 4: begin
                exp_q.push_back(e);
                w = e; w.rfw = 1; w.pcw = 1; w.dmux = 1;
                w.pcc = (kind == 4) ? 3'b001 : 3'b000;
                exp_q.push_back(w);
            end
            2: begin
                e.pcw = 1;
                if (ins[31:26] == 6'd4) e.pcc = z ? 3'b011 : 3'b000;
                else                    e.pcc = z ? 3'b000 : 3'b011;
                exp_q.push_back(e);
            end
            3: begin e.pcw = 1; e.pcc = 3'b001; exp_q.push_back(e); end
            5: begin e.pcw = 1; e.pcc = 3'b010; exp_q.push_back(e); end
            6, 7: begin
                exp_q.push_back(e);
                m = e;
                if (kind == 6) m.rden = 1; else m.dmw = lanes;
                for (int i = 0; i < ((d < WMAX) ? d : WMAX); i++)
                    exp_q.push_back(m);
                if (d >= WMAX) begin
                    t = e; t.tmo = 1; t.pcw = 1;
                    exp_q.push_back(t);
                end else begin
                    if (kind == 7) m.pcw = 1;
                    exp_q.push_back(m);
                    if (kind == 6) begin
                        w = e; w.rfw = 1; w.pcw = 1;
                        exp_q.push_back(w);
                    end
                end
            end
            default: begin e.ill = 1; e.pcw = 1; exp_q.push_back(e); end
        endcase
        exp_q.push_back(idle_o);
    endtask

    task automatic run(input string tag, input logic [31:0] ins,
                       input logic z, input int d);
        int n;
        build(ins, z, d);
        n = exp_q.size();
        for (int k = 0; k < n; k++) begin
            instruction_in = (k == 0) ? ins : $urandom;
            instr_valid = (k == 0) ? 1'b1 :
                          (k == n - 1) ? 1'b0 : 1'($urandom_range(0, 1));
            alu_zero  = z;
            mem_ready = (k >= 3 + d);
            @(negedge clk);
            tests++;
            assert (obs === exp_q[k]) else begin
                fails++;
                $error("FAIL %s cyc%0d observed=%h expected=%h",
                       tag, k, obs, exp_q[k]);
            end
            @(posedge clk);
            #1;
        end
    endtask

    logic [11:0] tpl [0:28];
    logic [31:0] r, ins;
    int          sel;

    initial begin
        idle_o = '0;
        idle_o.rdy = 1'b1;
        tpl = '{ {6'd0, 6'd0}, {6'd0, 6'd2}, {6'd0, 6'd3}, {6'd0, 6'd8},
                 {6'd0, 6'd32}, {6'd0, 6'd33}, {6'd0, 6'd34}, {6'd0, 6'd35},
                 {6'd0, 6'd36}, {6'd0, 6'd37}, {6'd0, 6'd38}, {6'd0, 6'd39},
                 {6'd0, 6'd42}, {6'd0, 6'd24}, {6'd0, 6'd16},
                 {6'd8, 6'd0}, {6'd9, 6'd0}, {6'd10, 6'd0}, {6'd12, 6'd0},
                 {6'd13, 6'd0}, {6'd4, 6'd0}, {6'd5, 6'd0}, {6'd2, 6'd0},
                 {6'd3, 6'd0}, {6'd35, 6'd0}, {6'd43, 6'd0}, {6'd41, 6'd0},
                 {6'd40, 6'd0}, {6'd15, 6'd0} };
        rst = 1'b1;
        instruction_in = '0;
        instr_valid = 1'b0;
        alu_zero = 1'b0;
        mem_ready = 1'b0;
        #12;
        tests++;
        assert (obs === idle_o) else begin
            fails++;
            $error("FAIL reset observed=%h expected=%h", obs, idle_o);
        end
        @(posedge clk);
        #1 rst = 1'b0;

        run("add", 32'h00221820, 1'b0, 0);
        run("beq_taken", 32'h10220004, 1'b1, 0);
        run("beq_not", 32'h10220004, 1'b0, 0);
        run("bne_taken", 32'h14220004, 1'b0, 0);
        run("bne_not", 32'h14220004, 1'b1, 0);
        run("lw_wait3", 32'h8C220008, 1'b0, 3);
        run("sw", 32'hAC220008, 1'b0, 0);
        run("sh", 32'hA4220008, 1'b0, 0);
        run("sb", 32'hA0220008, 1'b0, 0);
        run("sw_timeout", 32'hAC220008, 1'b0, 1000);
        run("lw_wait14", 32'h8C220008, 1'b0, 14);
        run("lw_timeout", 32'h8C220008, 1'b0, 15);
        run("j", 32'h08000010, 1'b0, 0);
        run("jal", 32'h0C000010, 1'b0, 0);
        run("jr", 32'h03E00008, 1'b0, 0);
        run("addi", 32'h20220005, 1'b0, 0);
        run("mult", 32'h00220018, 1'b0, 0);
        run("lui", 32'h3C010001, 1'b0, 0);

        // reset while a load stalls in MEM
        instruction_in = 32'h8C220008;
        instr_valid = 1'b1;
        mem_ready = 1'b0;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        assert (data_mem_rden === 1'b1) else begin
            fails++;
            $error("FAIL lw_stall_rden observed=%b expected=1", data_mem_rden);
        end
        #2 rst = 1'b1;
        #1;
        tests++;
        assert (obs === idle_o) else begin
            fails++;
            $error("FAIL async_reset observed=%h expected=%h", obs, idle_o);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        tests++;
        assert (obs === idle_o) else begin
            fails++;
            $error("FAIL post_reset observed=%h expected=%h", obs, idle_o);
        end
        run("add_after_rst", 32'h00221820, 1'b0, 0);

        for (int i = 0; i < 80; i++) begin
            r = $urandom;
            sel = $urandom_range(0, 29);
            if (sel == 29) begin
                ins = r;
            end else if (tpl[sel][11:6] == 6'd0) begin
                ins = {6'd0, r[25:6], tpl[sel][5:0]};
            end else begin
                ins = {tpl[sel][11:6], r[25:0]};
            end
            run("random", ins, 1'($urandom_range(0, 1)),
                $urandom_range(0, 17));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
